johnson_decoder: RTL and testbench
==================================

// Module: johnson_decoder
// PURPOSE
//   Receive-side companion to shift_counter: samples the 8-bit Johnson count, decodes it to a
//   binary phase index and checks legality plus the +1 step sequence every enabled clock.
//   Provides lock status, a one-cycle error pulse and a saturating error count for
//   self-check benches and downstream phase-select logic.
// PARAMETERS
//   WIDTH      8  Johnson code width; 2*WIDTH phases; IW = $clog2(2*WIDTH) (8 -> IW=4)
//   LOCK_CNT   2  consecutive correct +1 steps needed to assert locked (>=1)
//   ERR_CNT_W  8  width of the saturating error counter
// PORTS
//   clk        in   1          rising-edge clock
//   reset      in   1          synchronous, active-high
//   en         in   1          1 = sample/check count this edge; 0 = hold everything
//   count      in   WIDTH      Johnson code under test
//   index      out  IW         registered decoded phase 0..2*WIDTH-1
//   code_valid out  1          registered: last sampled code was legal
//   locked     out  1          sequence tracked for >= LOCK_CNT correct steps
//   seq_err    out  1          one-cycle pulse: sequence/legality error while not in HUNT
//   err_cnt    out  ERR_CNT_W  saturating count of seq_err pulses
//   err_sticky out  1          see CONFIGURATION
// BEHAVIOUR
//   Code map (matches count <= {count[W-2:0], ~count[W-1]}): phase i<=W -> i low ones;
//     i>W -> (2W-i) high ones. e.g. 00000000=0, 00000111=3, 11111111=8, 11111110=9, 10000000=15.
//   Legal: c is 0..01..1 ((c&(c+1))==0) or 1..10..0 ((~c&(~c+1))==0); otherwise illegal.
//   Decode: idx = (c[0] | c==0) ? popcount(c) : 2W-popcount(c). Illegal code: index holds.
//   Latency 1: index/code_valid update on the same edge that samples count (when en=1).
//   Good step: legal and idx == (prev+1) mod 2W; 15->0 is a good step. prev = last legal idx.
//   FSM (advances only when en=1; state, good counter, prev held when en=0):
//     HUNT   : legal -> CHECK, good=0, prev=idx; illegal -> stay. No seq_err in HUNT.
//     CHECK  : good step -> good+1; good+1==LOCK_CNT -> LOCKED.
//              legal bad step -> stay CHECK, good=0, prev=idx. illegal -> HUNT.
//     LOCKED : good step -> stay. legal bad step -> CHECK (good=0, prev=idx);
//              illegal -> HUNT.
//   Any bad step or illegal code in CHECK or LOCKED: seq_err=1 for exactly one cycle and
//     err_cnt increments, saturating at 2^ERR_CNT_W-1.
//   Repeated code (count frozen) with en=1 is a bad step.
//   locked = (state==LOCKED), registered; drops on the same edge that raises seq_err.
//   Reset (sync, high): state HUNT, good=0, prev=0, index=0, code_valid=0, locked=0,
//     seq_err=0, err_cnt=0, err_sticky=0. Reset beats en; reset mid-lock clears all
//     outputs on that edge.
//   en=0: all outputs hold, except seq_err, which returns to 0.
// CONFIGURATION
//   JOHNSON_DEC_STICKY_EN defined: err_sticky sets on the first seq_err and stays 1 until reset.
//   Undefined: err_sticky is tied to 0 and no sticky flop exists; all other behaviour unchanged.
// TESTING
//   1 reset 1 at t=50, 0 at t=65, then count 0,1,3,7 (binary 00000000..00000111) each edge, en=1
//     -> index 0,1,2,3; locked=1 at the edge sampling 00000011; seq_err never 1.
//   2 Locked; feed the full 16-code cycle twice (10000000 -> 00000000 wrap)
//     -> index 15->0, locked stays 1, err_cnt=0.
//   3 Locked at index 3; count=01010101
//     -> code_valid=0, seq_err=1 one cycle, err_cnt=1, locked=0, index holds 3, state HUNT.
//   4 Locked at 00000111 (3); feed 00011111 (5), then 00111111, 01111111
//     -> seq_err at 5; err_cnt+1; relock at 7 after 2 good steps.
//   5 Locked; en=0 for 3 cycles with count frozen -> no seq_err, outputs held;
//     en=1 with the next code -> locked stays 1.
//   6 ERR_CNT_W=2: force 5 errors -> err_cnt=3 (saturated); err_sticky=1 only with the macro;
//     reset for 1 edge -> all outputs 0.

Source files
------------

// File: rtl/johnson_decoder.sv
// Johnson-count receiver: decodes the code to a phase index, checks legality and +1 stepping,
// and reports lock / error status. Define JOHNSON_DEC_STICKY_EN to add a sticky error flag.
module johnson_decoder #(
  parameter int WIDTH     = 8,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8,
  localparam int IW       = $clog2(2 * WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     count,
  output logic [IW-1:0]        index,
  output logic                 code_valid,
  output logic                 locked,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_sticky
);

  localparam int GW                     = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] LOCK_VAL    = GW'(LOCK_CNT);
  // 2W wraps to 0 when it is a power of two, so PHASES - pop stays correct modulo 2^IW
  localparam logic [IW-1:0] PHASES      = IW'(2 * WIDTH);
  localparam logic [IW-1:0] LAST_PHASE  = IW'(2 * WIDTH - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state_r;
  logic [GW-1:0]   good_r;
  logic [IW-1:0]   prev_r;

  logic [IW-1:0]   pop_s;
  logic [IW-1:0]   idx_s;
  logic [IW-1:0]   expect_s;
  logic [GW-1:0]   good_inc_s;
  logic            legal_s;
  logic            good_step_s;
  logic            err_s;

  function automatic logic [IW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [IW-1:0] acc;
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc = acc + {{(IW-1){1'b0}}, v[i]};
    end
    return acc;
  endfunction

  // Decode, legality and step classification of the code presented this cycle
  always_comb begin
    pop_s       = popcount(count);
    legal_s     = ((count & (count + WIDTH'(1))) == '0) ||
                  ((~count & (~count + WIDTH'(1))) == '0);
    if (count[0] || (count == '0)) begin
      idx_s = pop_s;
    end else begin
      idx_s = PHASES - pop_s;
    end
    if (prev_r == LAST_PHASE) begin
      expect_s = '0;
    end else begin
      expect_s = prev_r + IW'(1);
    end
    good_inc_s  = good_r + GW'(1);
    good_step_s = legal_s && (idx_s == expect_s);
    err_s       = en && (state_r != HUNT) && !good_step_s;
  end

  // Lock FSM and registered outputs; seq_err follows err_s so it self-clears when en=0
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= HUNT;
      good_r     <= '0;
      prev_r     <= '0;
      index      <= '0;
      code_valid <= 1'b0;
      locked     <= 1'b0;
      seq_err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      seq_err <= err_s;
      if (err_s && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
      if (en) begin
        code_valid <= legal_s;
        if (legal_s) begin
          index  <= idx_s;
          prev_r <= idx_s;
        end
        case (state_r)
          HUNT: begin
            good_r <= '0;
            if (legal_s) begin
              state_r <= CHECK;
            end
          end
          CHECK: begin
            if (!legal_s) begin
              state_r <= HUNT;
              good_r  <= '0;
            end else if (good_step_s) begin
              good_r <= good_inc_s;
              if (good_inc_s == LOCK_VAL) begin
                state_r <= LOCKED;
                locked  <= 1'b1;
              end
            end else begin
              good_r <= '0;
            end
          end
          LOCKED: begin
            if (!legal_s) begin
              state_r <= HUNT;
              good_r  <= '0;
              locked  <= 1'b0;
            end else if (!good_step_s) begin
              state_r <= CHECK;
              good_r  <= '0;
              locked  <= 1'b0;
            end
          end
          default: begin
            state_r <= HUNT;
            good_r  <= '0;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef JOHNSON_DEC_STICKY_EN
  logic sticky_r;

  // Latches the first error until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_r <= 1'b0;
    end else if (err_s) begin
      sticky_r <= 1'b1;
    end
  end

  assign err_sticky = sticky_r;
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder: a table-driven phase model predicts every edge,
// a monitor compares the DUT outputs against the queued predictions.
module tb_johnson_decoder;

  localparam int W    = 8;
  localparam int LOCK = 2;
  localparam int ECW  = 2;
  localparam int NPH  = 2 * W;
  localparam int IW   = $clog2(NPH);
  localparam int EMAX = (1 << ECW) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           en = 1'b0;
  logic [W-1:0]   count = '0;
  logic [IW-1:0]  index;
  logic           code_valid;
  logic           locked;
  logic           seq_err;
  logic [ECW-1:0] err_cnt;
  logic           err_sticky;

  johnson_decoder #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_CNT_W(ECW)) dut (
    .clk(clk), .reset(reset), .en(en), .count(count),
    .index(index), .code_valid(code_valid), .locked(locked),
    .seq_err(seq_err), .err_cnt(err_cnt), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    int index; int cv; int locked; int serr; int ecnt; int sticky;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // model state
  exp_t m;
  int   m_hunting, m_prev, m_run;

  function automatic logic [W-1:0] code_of(input int i);
    logic [31:0] t;
    if (i <= W) t = (32'd1 << i) - 32'd1;
    else        t = ~((32'd1 << (W - (NPH - i))) - 32'd1);
    return t[W-1:0];
  endfunction

  function automatic int lookup(input logic [W-1:0] c);
    for (int i = 0; i < NPH; i++) if (code_of(i) == c) return i;
    return -1;
  endfunction

  task automatic model(input logic r, input logic e, input logic [W-1:0] c);
    int ph;
    int err;
    if (r) begin
      m = '{0, 0, 0, 0, 0, 0};
      m_hunting = 1; m_prev = 0; m_run = 0;
      return;
    end
    m.serr = 0;
    if (!e) return;
    ph  = lookup(c);
    err = 0;
    m.cv = (ph >= 0);
    if (ph >= 0) m.index = ph;
    if (m_hunting) begin
      if (ph >= 0) begin m_hunting = 0; m_run = 0; m_prev = ph; end
    end else if (ph < 0) begin
      err = 1; m_hunting = 1; m_run = 0; m.locked = 0;
    end else if (ph == (m_prev + 1) % NPH) begin
      m_prev = ph;
      if (m_run < LOCK) m_run++;
      if (m_run >= LOCK) m.locked = 1;
    end else begin
      err = 1; m_run = 0; m_prev = ph; m.locked = 0;
    end
    if (err) begin
      m.serr = 1;
      if (m.ecnt < EMAX) m.ecnt++;
`ifdef JOHNSON_DEC_STICKY_EN
      m.sticky = 1;
`endif
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [W-1:0] c);
    @(negedge clk);
    reset = r; en = e; count = c;
    model(r, e, c);
    q.push_back(m);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: one prediction per edge that had stimulus
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("index",      int'(index),      e.index);
      chk("code_valid", int'(code_valid), e.cv);
      chk("locked",     int'(locked),     e.locked);
      chk("seq_err",    int'(seq_err),    e.serr);
      chk("err_cnt",    int'(err_cnt),    e.ecnt);
      chk("err_sticky", int'(err_sticky), e.sticky);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ph, r;
    logic [W-1:0] c;
    m = '{0, 0, 0, 0, 0, 0};
    m_hunting = 1; m_prev = 0; m_run = 0;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, code_of(5));
    // acquire lock, then two full cycles including the 15 -> 0 wrap
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, code_of(i));
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, code_of((4 + k) % NPH));
    c = 8'b0101_0101;
    step(1'b0, 1'b1, c);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, code_of(i));
    step(1'b0, 1'b1, code_of(5));
    step(1'b0, 1'b1, code_of(6));
    step(1'b0, 1'b1, code_of(7));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, code_of(7));
    step(1'b0, 1'b1, code_of(8));
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, code_of(8));
    step(1'b1, 1'b1, code_of(9));
    step(1'b0, 1'b0, code_of(9));
    // randomized traffic
    ph = 0;
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      begin ph = (ph + 1) % NPH; c = code_of(ph); end
      else if (r < 78) c = code_of(ph);
      else if (r < 86) begin ph = $urandom_range(0, NPH - 1); c = code_of(ph); end
      else if (r < 94) c = W'($urandom);
      else             c = 8'b0110_0011;
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, c);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
